// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM encoding, instruction
// field positions and the opcode constants used by the control unit.
package mips_pkg;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int JUMP_IDX_W = 26;
  localparam int WORD_BYTES = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  function automatic logic [31:0] sign_ext16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the fetch stage: sequential PC+4, branch and jump
// targets, with the older branch taking priority over a jump.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0]           pc_i,
  input  logic                  branch_taken_i,
  input  logic [31:0]           branch_pc4_i,
  input  logic [15:0]           branch_offset_i,
  input  logic                  jump_i,
  input  logic [3:0]            jump_region_i,
  input  logic [JUMP_IDX_W-1:0] jump_idx_i,
  output logic [31:0]           pc_plus4_o,
  output logic                  redirect_o,
  output logic [31:0]           redirect_pc_o
);

  logic [31:0] btarget;
  logic [31:0] jtarget;

  assign pc_plus4_o    = pc_i + 32'(WORD_BYTES);
  assign btarget       = branch_pc4_i + (sign_ext16(branch_offset_i) << 2);
  assign jtarget       = {jump_region_i, jump_idx_i, 2'b00};
  assign redirect_o    = branch_taken_i | jump_i;
  assign redirect_pc_o = branch_taken_i ? btarget : jtarget;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC, req/ack instruction-memory interface,
// one-entry stall buffer and IF/ID register, with branch/jump redirect.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;

  next_pc_sel u_next_pc_sel (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_pc4_i    (branch_pc4),
    .branch_offset_i (branch_offset),
    .jump_i          (jump),
    .jump_region_i   (pc4_q[31:28]),
    .jump_idx_i      (instr_q[JUMP_IDX_W-1:0]),
    .pc_plus4_o      (pc_plus4),
    .redirect_o      (redirect),
    .redirect_pc_o   (redirect_pc)
  );

  // A redirect flushes IF/ID and the buffer; if the current request is still
  // unanswered, DROP keeps presenting its address until the stale ack arrives.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;

    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          if (!imem_ack) begin
            state_d     = ST_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (stall) begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = ST_FULL;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (!stall) begin
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (!redirect && imem_ack) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req    = (state_q != ST_FULL);
  assign imem_addr   = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a latency-randomizing memory and
// a program-order stream model of what decode should consume.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc4 = '0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] if_id_instr2;
  logic [31:0] if_id_pc42;
  logic        if_id_valid2;
  logic [5:0]  opcode2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] obsPc4;
    logic [31:0] obsInstr;
    logic [31:0] expPc4;
    logic [31:0] expInstr;
  } cons_t;

  cons_t       consQ[$];
  logic [31:0] expPc = '0;
  logic        pending = 1'b0;
  logic [31:0] reqAddr = '0;
  int          waitCnt = 0;
  int          latMin = 0;
  int          latMax = 0;
  int          hsViol = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_pc4    (branch_pc4),
    .branch_offset (branch_offset),
    .jump          (jump),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req2),
    .imem_addr     (imem_addr2),
    .imem_ack      (rst_n),
    .imem_rdata    (32'h1234_5678),
    .stall         (1'b0),
    .branch_taken  (1'b0),
    .branch_pc4    (32'h0),
    .branch_offset (16'h0),
    .jump          (1'b0),
    .if_id_instr   (if_id_instr2),
    .if_id_pc4     (if_id_pc42),
    .if_id_valid   (if_id_valid2),
    .opcode        (opcode2)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h8C01_0004;
    if (a == 32'h0000_0004) return 32'h0000_0020;
    if (a == 32'hA000_0000) return 32'h0800_0100;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic doReset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pending = 1'b0;
    expPc = 32'h0;
    consQ.delete();
  endtask

  // One clock: memory answers the current request, and the stream model
  // records what decode consumes or where a redirect restarts the program.
  task automatic step();
    cons_t       c;
    logic [31:0] word;
    logic [31:0] nextPc4;
    if (imem_req) begin
      if (!pending) begin
        waitCnt = int'($urandom_range(latMax, latMin));
        reqAddr = imem_addr;
      end else if (imem_addr !== reqAddr) begin
        hsViol++;
      end
      if (imem_addr[1:0] !== 2'b00) hsViol++;
      if (waitCnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = memf(imem_addr);
        pending = 1'b0;
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        waitCnt--;
        pending = 1'b1;
      end
    end else begin
      if (pending) hsViol++;
      imem_ack = 1'b0;
    end
    if (!(branch_taken || jump) && if_id_valid && !stall) begin
      c.obsPc4 = if_id_pc4;
      c.obsInstr = if_id_instr;
      c.expPc4 = expPc + 32'd4;
      c.expInstr = memf(expPc);
      consQ.push_back(c);
      expPc = expPc + 32'd4;
    end else if (branch_taken) begin
      expPc = branch_pc4 + 32'(int'($signed(branch_offset)) * 4);
    end else if (jump) begin
      word = memf(expPc);
      nextPc4 = expPc + 32'd4;
      expPc = {nextPc4[31:28], word[25:0], 2'b00};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h exp 00000000", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h exp 00000000", if_id_instr); end
    checks++; if (if_id_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4 got %h exp 00000000", if_id_pc4); end
    checks++; if (opcode !== 6'h0) begin errors++; $display("[TB] FAIL reset_opcode got %h exp 00", opcode); end
    latMin = 0; latMax = 0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL async_reset valid/pc4 got %b/%h exp 0/00000000", if_id_valid, if_id_pc4); end
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL async_reset addr/req got %h/%b exp 00000000/1", imem_addr, imem_req); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    doReset();
    latMin = 0; latMax = 0;
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h4) begin errors++; $display("[TB] FAIL first_fetch valid/pc4 got %b/%h exp 1/00000004", if_id_valid, if_id_pc4); end
    checks++; if (if_id_instr !== 32'h8C01_0004 || opcode !== 6'b100011) begin errors++; $display("[TB] FAIL first_fetch instr/op got %h/%b exp 8c010004/100011", if_id_instr, opcode); end
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h8) begin errors++; $display("[TB] FAIL second_fetch valid/pc4 got %b/%h exp 1/00000008", if_id_valid, if_id_pc4); end
    checks++; if (opcode !== 6'b000000) begin errors++; $display("[TB] FAIL second_fetch opcode got %b exp 000000", opcode); end
    repeat (6) step();
    checks++; if (consQ.size() != 7) begin errors++; $display("[TB] FAIL throughput consumed got %0d exp 7", consQ.size()); end
    foreach (consQ[i]) begin
      checks++;
      if (consQ[i].obsPc4 !== consQ[i].expPc4 || consQ[i].obsInstr !== consQ[i].expInstr) begin
        errors++;
        $display("[TB] FAIL b2b_stream[%0d] got %h/%h exp %h/%h", i, consQ[i].obsPc4, consQ[i].obsInstr, consQ[i].expPc4, consQ[i].expInstr);
      end
    end
    consQ.delete();
  endtask

  task automatic test_stall();
    latMin = 0; latMax = 0;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req[%0d] got %b exp 0", k, imem_req); end
      checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== expPc + 32'd4) begin errors++; $display("[TB] FAIL stall_hold[%0d] got %b/%h exp 1/%h", k, if_id_valid, if_id_pc4, expPc + 32'd4); end
    end
    stall = 1'b0;
    step();
    checks++; if (if_id_pc4 !== expPc + 32'd4 || if_id_instr !== memf(expPc)) begin errors++; $display("[TB] FAIL stall_release got %h/%h exp %h/%h", if_id_pc4, if_id_instr, expPc + 32'd4, memf(expPc)); end
    checks++; if (imem_addr !== expPc + 32'd4) begin errors++; $display("[TB] FAIL stall_next_addr got %h exp %h", imem_addr, expPc + 32'd4); end
    repeat (3) step();
    foreach (consQ[i]) begin
      checks++;
      if (consQ[i].obsPc4 !== consQ[i].expPc4 || consQ[i].obsInstr !== consQ[i].expInstr) begin
        errors++;
        $display("[TB] FAIL stall_stream[%0d] got %h/%h exp %h/%h", i, consQ[i].obsPc4, consQ[i].obsInstr, consQ[i].expPc4, consQ[i].expInstr);
      end
    end
    consQ.delete();
  endtask

  task automatic test_branch();
    latMin = 0; latMax = 0;
    branch_taken = 1'b1; branch_pc4 = 32'h0000_0010; branch_offset = 16'hFFFE;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'h0000_0008) begin errors++; $display("[TB] FAIL branch_addr got %h exp 00000008", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL branch_flush got %b exp 0", if_id_valid); end
    step();
    checks++; if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h0000_000C) begin errors++; $display("[TB] FAIL branch_target_word got %b/%h exp 1/0000000c", if_id_valid, if_id_pc4); end
    consQ.delete();
  endtask

  task automatic test_jump();
    latMin = 0; latMax = 0;
    branch_taken = 1'b1; branch_pc4 = 32'hA000_0000; branch_offset = 16'h0000;
    step();
    branch_taken = 1'b0;
    step();
    checks++; if (if_id_pc4 !== 32'hA000_0004 || opcode !== 6'b000010) begin errors++; $display("[TB] FAIL jump_setup got %h/%b exp a0000004/000010", if_id_pc4, opcode); end
    jump = 1'b1;
    step();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'hA000_0400) begin errors++; $display("[TB] FAIL jump_addr got %h exp a0000400", imem_addr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL jump_flush got %b exp 0", if_id_valid); end
    repeat (2) step();
    jump = 1'b1; branch_taken = 1'b1; branch_pc4 = 32'h0000_0010; branch_offset = 16'hFFFE;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    checks++; if (imem_addr !== 32'h0000_0008) begin errors++; $display("[TB] FAIL branch_over_jump got %h exp 00000008", imem_addr); end
    repeat (3) step();
    foreach (consQ[i]) begin
      checks++;
      if (consQ[i].obsPc4 !== consQ[i].expPc4 || consQ[i].obsInstr !== consQ[i].expInstr) begin
        errors++;
        $display("[TB] FAIL jump_stream[%0d] got %h/%h exp %h/%h", i, consQ[i].obsPc4, consQ[i].obsInstr, consQ[i].expPc4, consQ[i].expInstr);
      end
    end
    consQ.delete();
  endtask

  task automatic test_redirect_delayed();
    doReset();
    latMin = 2; latMax = 2;
    branch_taken = 1'b1; branch_pc4 = 32'h0000_0100; branch_offset = 16'h0000;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL drop_hold1 got %b/%h exp 1/00000000", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL drop_hold2 got %b/%h exp 1/00000000", imem_req, imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h0000_0100 || if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL drop_retarget got %h/%b exp 00000100/0", imem_addr, if_id_valid); end
    latMin = 0; latMax = 0;
    repeat (4) step();
    checks++; if (consQ.size() == 0 || consQ[0].obsPc4 !== 32'h0000_0104) begin errors++; $display("[TB] FAIL drop_first_word got %0d entries exp first pc4 00000104", consQ.size()); end
    foreach (consQ[i]) begin
      checks++;
      if (consQ[i].obsPc4 !== consQ[i].expPc4 || consQ[i].obsInstr !== consQ[i].expInstr) begin
        errors++;
        $display("[TB] FAIL drop_stream[%0d] got %h/%h exp %h/%h", i, consQ[i].obsPc4, consQ[i].obsInstr, consQ[i].expPc4, consQ[i].expInstr);
      end
    end
    consQ.delete();
  endtask

  task automatic test_random();
    int total;
    doReset();
    hsViol = 0;
    total = 0;
    latMin = 0; latMax = 3;
    for (int k = 0; k < 600; k++) begin
      stall = ($urandom_range(9, 0) < 3);
      branch_taken = ($urandom_range(19, 0) == 0);
      branch_pc4 = $urandom & 32'hFFFF_FFFC;
      branch_offset = 16'($urandom);
      step();
    end
    stall = 1'b0; branch_taken = 1'b0;
    repeat (10) step();
    total = consQ.size();
    checks++; if (total < 60) begin errors++; $display("[TB] FAIL random_progress consumed %0d exp at least 60", total); end
    checks++; if (hsViol != 0) begin errors++; $display("[TB] FAIL random_handshake violations %0d exp 0", hsViol); end
    foreach (consQ[i]) begin
      checks++;
      if (consQ[i].obsPc4 !== consQ[i].expPc4 || consQ[i].obsInstr !== consQ[i].expInstr) begin
        errors++;
        $display("[TB] FAIL random_stream[%0d] got %h/%h exp %h/%h", i, consQ[i].obsPc4, consQ[i].obsInstr, consQ[i].expPc4, consQ[i].expInstr);
      end
    end
    consQ.delete();
  endtask

  task automatic test_reset_pc_wrap();
    doReset();
    checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_first_addr got %b/%h exp 1/fffffffc", imem_req2, imem_addr2); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (imem_addr2 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_second_addr got %h exp 00000000", imem_addr2); end
    checks++; if (if_id_valid2 !== 1'b1 || if_id_pc42 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4 got %b/%h exp 1/00000000", if_id_valid2, if_id_pc42); end
    checks++; if (if_id_instr2 !== 32'h1234_5678 || opcode2 !== 6'b000100) begin errors++; $display("[TB] FAIL wrap_word got %h/%b exp 12345678/000100", if_id_instr2, opcode2); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_branch();
    test_jump();
    test_redirect_delayed();
    test_random();
    test_reset_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the MIPS pipeline. Holds the program counter and issues word requests to instruction memory over a req/ack handshake. Captures returned words into the IF/ID register, and exposes `opcode` (`if_id_instr[31:26]`) directly to the control unit. Handles decode stalls with a one-entry buffer, and handles taken-branch and jump redirects, including a redirect that arrives while a memory request is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  request valid; address is held stable until `imem_ack`.
- `imem_addr`  out  32  word address (bits [1:0] always 0).
- `imem_ack`  in  1  `imem_rdata` is valid this cycle; may arrive in the same cycle as the request or any later cycle.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept; IF/ID holds its contents.
- `branch_taken`  in  1  taken branch resolved downstream.
- `branch_pc4`  in  32  PC+4 of the branch instruction.
- `branch_offset`  in  16  raw branch immediate.
- `jump`  in  1  jump decoded from the current IF/ID instruction.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a live instruction.
- `opcode`  out  6  `if_id_instr[31:26]`; combinational; feeds the control unit.

## Operation
- States:
  - **REQ**: `imem_req` = 1, `imem_addr` = `pc`.
  - **FULL**: a word is buffered, `imem_req` = 0.
  - **DROP**: a stale response is outstanding, `imem_req` = 1 at the old address.
- Target arithmetic, all modulo 2^32:
  - `btarget` = `branch_pc4` + (sign-extended `branch_offset` << 2).
  - `jtarget` = {`if_id_pc4[31:28]`, `if_id_instr[25:0]`, 2'b00}.
  - PC+4 wraps 32'hFFFF_FFFC -> 0.
- Redirect = `branch_taken` | `jump`. `branch_taken` has priority over `jump`, since the branch is the older instruction. Redirect has priority over `stall`.
- Redirect, any state:
  - `pc` <= selected target.
  - `if_id_valid` <= 0.
  - The FULL buffer is discarded.
- Redirect destination state:
  - REQ with no ack this cycle: go to DROP.
  - REQ with ack this cycle: the word is discarded; go to REQ.
  - FULL: go to REQ.
  - DROP: stay in DROP.
- REQ, ack, not `stall`:
  - `if_id_instr` <= `imem_rdata`.
  - `if_id_pc4` <= `pc`+4.
  - `if_id_valid` <= 1.
  - `pc` <= `pc`+4.
  - Stay in REQ.
- REQ, ack, `stall`: buffer the word and its `pc`+4, `pc` <= `pc`+4, go to FULL. IF/ID is unchanged.
- REQ, no ack, not `stall`: `if_id_valid` <= 0 (bubble).
- REQ, no ack, `stall`: IF/ID is unchanged.
- FULL, not `stall`: buffer moves into IF/ID with `if_id_valid` = 1; go to REQ.
- FULL, `stall`: hold everything.
- DROP, ack: the word is discarded; go to REQ, which issues at the new `pc`.
- DROP, no ack: stay in DROP. `imem_addr` stays at the old address, held in a separate register, to respect the handshake.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; state = REQ.
  - `imem_req` = 1, `imem_addr` = `RESET_PC`.
  - `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0, `opcode` = 0.
  - Memory ignores requests while `rst_n` = 0.
- Reset mid-operation: all state returns to reset values immediately. Any pending ack after release belongs to the new REQ; the memory is reset together with this block.
- Latency:
  - Zero-wait memory: ack in cycle N gives `if_id_valid` = 1 after edge N.
  - Throughput: one instruction per cycle.
- Redirect at edge N: the first fetch of the target is issued in cycle N+1 (REQ/FULL), or the cycle after the stale ack (DROP).
- `stall` never drops or duplicates an instruction. Every non-flushed word appears in IF/ID exactly once, in program order.

## Structure
- Shared package `mips_pkg`:
  - state encoding (REQ/FULL/DROP);
  - `OPCODE_MSB`/`LSB` = 31/26;
  - `JUMP_IDX_W` = 26;
  - `WORD_BYTES` = 4.
  - The control-unit opcode constants move into the same package.
- One natural sub-module: `next_pc_sel`, combinational. It computes `btarget`, `jtarget` and PC+4, and applies redirect priority.

## Test plan
- Reset release, zero-wait memory returning 32'h8C01_0004, 32'h0000_0020 -> `if_id_pc4` = 4 then 8. `opcode` = 6'b100011 then 6'b000000.
- Ack with `stall` high for 3 cycles -> `imem_req` = 0 during FULL. On stall release, IF/ID = buffered word. Next `imem_addr` = old `pc`+4; no word lost.
- `branch_taken` = 1, `branch_pc4` = 32'h0000_0010, `branch_offset` = 16'hFFFE -> next `imem_addr` = 32'h0000_0008, `if_id_valid` = 0.
- `jump` with `if_id_pc4` = 32'hA000_0004, index 26'h0000_100 -> `imem_addr` = 32'hA000_0400. Simultaneous `branch_taken` -> `btarget` wins.
- Redirect while ack delayed 2 cycles -> `imem_addr` holds the old address until ack. That word never reaches IF/ID; the next request is to the target.
- `RESET_PC` = 32'hFFFF_FFFC -> second fetch address = 32'h0000_0000.
